arbitro_actuadores: RTL and testbench



---
 rtl/arbitro_actuadores.sv | 113 +++++++++++
 tb/tb_arbitro_actuadores.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_actuadores.sv
// arbitro_actuadores: arbitrates the single actuator power stage between
// heater and fan requests. Keeps the two drives mutually exclusive, inserts
// a dead time after every on-period, holds a minimum on-time and forces a
// rest after a maximum continuous on-time (suspended while alerta=1).
// Optional statistics counters are built when ESTADISTICAS_EN is defined.
module arbitro_actuadores #(
  parameter int T_MUERTO   = 4,
  parameter int T_MIN_ON   = 8,
  parameter int T_MAX_ON   = 64,
  parameter int T_DESCANSO = 16,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       habilitar,
  input  logic       req_calef,
  input  logic       req_vent,
  input  logic       alerta,
  output logic       calefactor_out,
  output logic       ventilador_out,
  output logic       conflicto,
  output logic [2:0] estado_arb
`ifdef ESTADISTICAS_EN
  ,
  output logic [15:0] num_activaciones,
  output logic [7:0]  num_descansos
`endif
);

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    CALEF_ON = 3'd1,
    VENT_ON  = 3'd2,
    MUERTO   = 3'd3,
    DESCANSO = 3'd4
  } estado_t;

  // Last counter value of each timed interval (cnt starts at 0 on entry).
  localparam logic [CNT_W-1:0] MUERTO_LAST   = CNT_W'(T_MUERTO - 1);
  localparam logic [CNT_W-1:0] MIN_ON_LAST   = CNT_W'(T_MIN_ON - 1);
  localparam logic [CNT_W-1:0] MAX_ON_LAST   = CNT_W'(T_MAX_ON - 1);
  localparam logic [CNT_W-1:0] DESCANSO_LAST = CNT_W'(T_DESCANSO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  estado_t          state;
  estado_t          state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             req_own;
  logic             req_other;

  // Next-state decision; precedence in the on-states is habilitar, then
  // release (only after the minimum on-time), then the max-on limit.
  always_comb begin
    state_nxt = REPOSO;
    req_own   = 1'b0;
    req_other = 1'b0;
    case (state)
      REPOSO: begin
        if (habilitar && req_calef && !req_vent)      state_nxt = CALEF_ON;
        else if (habilitar && req_vent && !req_calef) state_nxt = VENT_ON;
        else                                          state_nxt = REPOSO;
      end
      CALEF_ON, VENT_ON: begin
        req_own   = (state == CALEF_ON) ? req_calef : req_vent;
        req_other = (state == CALEF_ON) ? req_vent  : req_calef;
        if (!habilitar)                                    state_nxt = MUERTO;
        else if ((!req_own || req_other) && cnt >= MIN_ON_LAST) state_nxt = MUERTO;
        else if (!alerta && cnt >= MAX_ON_LAST)            state_nxt = DESCANSO;
        else                                               state_nxt = state;
      end
      MUERTO:   state_nxt = (cnt >= MUERTO_LAST)   ? REPOSO : MUERTO;
      DESCANSO: state_nxt = (cnt >= DESCANSO_LAST) ? REPOSO : DESCANSO;
      default:  state_nxt = REPOSO;
    endcase
  end

  // State, saturating dwell counter and drives decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= REPOSO;
      cnt            <= '0;
      calefactor_out <= 1'b0;
      ventilador_out <= 1'b0;
      conflicto      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      calefactor_out <= (state_nxt == CALEF_ON);
      ventilador_out <= (state_nxt == VENT_ON);
      conflicto      <= (state == REPOSO) && req_calef && req_vent;
    end
  end

  assign estado_arb = state;

`ifdef ESTADISTICAS_EN
  // Saturating tallies of grants and forced rests.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_activaciones <= '0;
      num_descansos    <= '0;
    end else begin
      if ((state_nxt == CALEF_ON || state_nxt == VENT_ON) && state_nxt != state &&
          num_activaciones != 16'hFFFF)
        num_activaciones <= num_activaciones + 16'd1;
      if (state_nxt == DESCANSO && state != DESCANSO && num_descansos != 8'hFF)
        num_descansos <= num_descansos + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_arbitro_actuadores.sv
// Bench for arbitro_actuadores: a behavioural model predicts every output
// cycle by cycle through a scoreboard queue, plus directed duration checks.
module tb_arbitro_actuadores;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       habilitar = 1'b0;
  logic       req_calef = 1'b0;
  logic       req_vent = 1'b0;
  logic       alerta = 1'b0;
  logic       calefactor_out;
  logic       ventilador_out;
  logic       conflicto;
  logic [2:0] estado_arb;
`ifdef ESTADISTICAS_EN
  logic [15:0] num_activaciones;
  logic [7:0]  num_descansos;
`endif

  arbitro_actuadores dut (
    .clk            (clk),
    .rst            (rst),
    .habilitar      (habilitar),
    .req_calef      (req_calef),
    .req_vent       (req_vent),
    .alerta         (alerta),
    .calefactor_out (calefactor_out),
    .ventilador_out (ventilador_out),
    .conflicto      (conflicto),
    .estado_arb     (estado_arb)
`ifdef ESTADISTICAS_EN
    ,
    .num_activaciones (num_activaciones),
    .num_descansos    (num_descansos)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cal;
    logic        vent;
    logic        conf;
    logic [2:0]  est;
    logic [15:0] act;
    logic [7:0]  desc;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int misses  = 0;

  // model state
  int   m_state = 0;
  int   m_age   = 0;
  logic m_conf  = 1'b0;
  int   m_act   = 0;
  int   m_desc  = 0;

  // observation tallies
  int cyc, cnt_cal, cnt_vent, cnt_desc, cnt_mu, cnt_conf, last_cal, first_vent;

  task automatic clr();
    cyc = 0; cnt_cal = 0; cnt_vent = 0; cnt_desc = 0; cnt_mu = 0; cnt_conf = 0;
    last_cal = -1; first_vent = -1;
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      misses++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic h, input logic c, input logic v, input logic a);
    int   ns;
    exp_t e;
    exp_t o;
    logic [5:0] obs_main;
    logic [5:0] exp_main;
    rst = r; habilitar = h; req_calef = c; req_vent = v; alerta = a;
    if (r) begin
      m_state = 0; m_age = 0; m_conf = 1'b0; m_act = 0; m_desc = 0;
    end else begin
      ns = 0;
      case (m_state)
        0: begin
          if (h && c && !v)      ns = 1;
          else if (h && v && !c) ns = 2;
          else                   ns = 0;
        end
        1, 2: begin
          logic mine, other;
          mine  = (m_state == 1) ? c : v;
          other = (m_state == 1) ? v : c;
          if (!h)                             ns = 3;
          else if ((!mine || other) && m_age >= 7) ns = 3;
          else if (!a && m_age >= 63)         ns = 4;
          else                                ns = m_state;
        end
        3: ns = (m_age >= 3) ? 0 : 3;
        4: ns = (m_age >= 15) ? 0 : 4;
        default: ns = 0;
      endcase
      m_conf = (m_state == 0) && c && v;
      if ((ns == 1 || ns == 2) && ns != m_state && m_act < 65535) m_act++;
      if (ns == 4 && m_state != 4 && m_desc < 255) m_desc++;
      if (ns == m_state) m_age = (m_age < 65535) ? m_age + 1 : m_age;
      else               m_age = 0;
      m_state = ns;
    end
    e.cal  = (m_state == 1);
    e.vent = (m_state == 2);
    e.conf = m_conf;
    e.est  = 3'(m_state);
    e.act  = 16'(m_act);
    e.desc = 8'(m_desc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    obs_main = {calefactor_out, ventilador_out, conflicto, estado_arb};
    exp_main = {o.cal, o.vent, o.conf, o.est};
    vectors++;
    assert (obs_main === exp_main) else begin
      misses++;
      $error("FAIL outputs cyc=%0d observed{cal,vent,conf,est}=%b expected=%b", cyc, obs_main, exp_main);
    end
    vectors++;
    assert (!(calefactor_out === 1'b1 && ventilador_out === 1'b1)) else begin
      misses++;
      $error("FAIL exclusive cyc=%0d observed both drives=1 expected at most one", cyc);
    end
`ifdef ESTADISTICAS_EN
    vectors++;
    assert ({num_activaciones, num_descansos} === {o.act, o.desc}) else begin
      misses++;
      $error("FAIL stats observed act=%0d desc=%0d expected act=%0d desc=%0d",
             num_activaciones, num_descansos, o.act, o.desc);
    end
`endif
    cyc++;
    if (calefactor_out === 1'b1) begin cnt_cal++; last_cal = cyc; end
    if (ventilador_out === 1'b1) begin
      cnt_vent++;
      if (first_vent < 0) first_vent = cyc;
    end
    if (estado_arb === 3'd4) cnt_desc++;
    if (estado_arb === 3'd3) cnt_mu++;
    if (conflicto === 1'b1) cnt_conf++;
  endtask

  initial begin
    clr();
    // reset held two cycles with a pending heater request
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check_int("reset_no_drive", cnt_cal + cnt_vent, 0);
    step(0, 1, 1, 0, 0);
    check_int("release_grant", int'(calefactor_out), 1);
    repeat (15) step(0, 1, 0, 0, 0);

    // short request: exactly T_MIN_ON drive, then T_MUERTO dead cycles
    clr();
    repeat (2) step(0, 1, 1, 0, 0);
    repeat (20) step(0, 1, 0, 0, 0);
    check_int("short_on_cycles", cnt_cal, 8);
    check_int("short_dead_cycles", cnt_mu, 4);
    check_int("short_end_state", int'(estado_arb), 0);

    // handover heater -> fan
    clr();
    repeat (20) step(0, 1, 1, 0, 0);
    repeat (30) step(0, 1, 0, 1, 0);
    check_int("handover_gap", first_vent - (last_cal + 1), 5);
    check_int("handover_heat_cycles", cnt_cal, 20);
    repeat (20) step(0, 1, 0, 0, 0);

    // max-on limit with forced rest, then re-grant
    clr();
    repeat (81) step(0, 1, 0, 1, 0);
    check_int("maxon_on_cycles", cnt_vent, 64);
    check_int("maxon_rest_cycles", cnt_desc, 16);
    repeat (9) step(0, 1, 0, 1, 0);
    check_int("maxon_regrant", int'(ventilador_out), 1);
    repeat (10) step(0, 1, 0, 0, 0);

    // alerta suspends the limit; dropping it past the limit forces rest
    clr();
    repeat (210) step(0, 1, 0, 1, 1);
    check_int("alerta_on_cycles", cnt_vent, 210);
    step(0, 1, 0, 1, 0);
    check_int("alerta_drop_rest", int'(estado_arb), 4);
    repeat (6) step(0, 0, 1, 1, 0);
    repeat (20) step(0, 1, 0, 0, 0);

    // conflict then disable mid on-period
    clr();
    repeat (3) step(0, 1, 1, 1, 0);
    check_int("conflict_cycles", cnt_conf, 3);
    check_int("conflict_no_drive", cnt_cal + cnt_vent, 0);
    repeat (3) step(0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check_int("disable_on_cycles", cnt_cal, 3);
    check_int("disable_to_dead", int'(estado_arb), 3);
    repeat (8) step(0, 0, 1, 0, 0);
    check_int("disabled_idle", int'(calefactor_out), 0);

    // reset in the middle of an on-period
    repeat (3) step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    check_int("midrun_reset", int'(calefactor_out), 0);
    repeat (4) step(0, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

  // hard time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

endmodule
